// File: rtl/collision_arbiter_pkg.sv
// Shared types and helpers for the sprite collision arbiter.
// Optional build macro: COLL_ARENA_BOUNDS_EN (arena edge check in collision_arbiter).
package coll_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    RESP = 2'd2
  } state_e;

  localparam int COORD_W_DEF = 10;
  localparam int CHAR_W_DEF  = 20;
  localparam int CHAR_H_DEF  = 20;

  // Widest coordinate the overlap helper accepts; narrower coordinates are zero-extended.
  localparam int COORD_MAX_W = 16;
  typedef logic [COORD_MAX_W-1:0] coord_t;

  // Strict AABB overlap: boxes whose edges only touch (distance == size) do not overlap.
  function automatic logic aabb_overlap(input coord_t ax, input coord_t ay,
                                        input coord_t bx, input coord_t by,
                                        input int w, input int h);
    logic [COORD_MAX_W:0] dx;
    logic [COORD_MAX_W:0] dy;
    dx = (ax >= bx) ? ({1'b0, ax} - {1'b0, bx}) : ({1'b0, bx} - {1'b0, ax});
    dy = (ay >= by) ? ({1'b0, ay} - {1'b0, by}) : ({1'b0, by} - {1'b0, ay});
    return (int'(dx) < w) && (int'(dy) < h);
  endfunction

endpackage

// File: rtl/collision_arbiter_rr.sv
// Combinational round-robin picker: first set request strictly after the last winner.
module rr_arbiter #(
  parameter  int N  = 4,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] last_i,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] idx_o,
  output logic          valid_o
);

  logic [IW-1:0] cand;

  always_comb begin
    gnt_o   = '0;
    idx_o   = '0;
    valid_o = 1'b0;
    cand    = '0;
    for (int k = 1; k <= N; k++) begin
      cand = IW'((int'(last_i) + k) % N);
      if (!valid_o && req_i[cand]) begin
        valid_o     = 1'b1;
        idx_o       = cand;
        gnt_o[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/collision_arbiter.sv
// Round-robin move-legality checker for N sprites; serial AABB scan over a position snapshot.
// Optional build macro: COLL_ARENA_BOUNDS_EN (also deny moves that leave the arena).
//
//  state | meaning
//  IDLE  | waiting for any req; accepts the round-robin winner and snapshots positions
//  SCAN  | one candidate per cycle, accumulating hit
//  RESP  | one-cycle resp_valid with resp_allowed = ~hit
module collision_arbiter
  import coll_pkg::*;
#(
  parameter  int N_CHAR  = 4,
  parameter  int COORD_W = COORD_W_DEF,
  parameter  int CHAR_W  = CHAR_W_DEF,
  parameter  int CHAR_H  = CHAR_H_DEF,
  parameter  int ARENA_W = 640,
  parameter  int ARENA_H = 480,
  localparam int IDW     = $clog2(N_CHAR)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [N_CHAR-1:0]           req,
  input  logic [N_CHAR*COORD_W-1:0]   req_x,
  input  logic [N_CHAR*COORD_W-1:0]   req_y,
  input  logic [N_CHAR*COORD_W-1:0]   pos_x,
  input  logic [N_CHAR*COORD_W-1:0]   pos_y,
  input  logic [N_CHAR-1:0]           alive,
  output logic [N_CHAR-1:0]           gnt,
  output logic                        busy,
  output logic                        resp_valid,
  output logic                        resp_allowed,
  output logic [IDW-1:0]              resp_id
);

  localparam logic [IDW-1:0] J_LAST = IDW'(N_CHAR - 1);

  state_e              state_q, state_d;
  logic [IDW-1:0]      rr_q, rr_d;
  logic [IDW-1:0]      id_q, id_d;
  logic [IDW-1:0]      j_q, j_d;
  logic                hit_q, hit_d;
  logic [N_CHAR-1:0]   gnt_q, gnt_d;
  logic [COORD_W-1:0]  tx_q, tx_d, ty_q, ty_d;
  logic [COORD_W-1:0]  px_q [N_CHAR];
  logic [COORD_W-1:0]  px_d [N_CHAR];
  logic [COORD_W-1:0]  py_q [N_CHAR];
  logic [COORD_W-1:0]  py_d [N_CHAR];
  logic [N_CHAR-1:0]   alive_q, alive_d;

  logic [COORD_W-1:0]  rx_arr [N_CHAR];
  logic [COORD_W-1:0]  ry_arr [N_CHAR];
  logic [N_CHAR-1:0]   arb_gnt;
  logic [IDW-1:0]      arb_idx;
  logic                arb_valid;
  logic                cand_ok;
  logic                cand_hit;
  logic                arena_hit;

  rr_arbiter #(.N(N_CHAR)) u_rr (
    .req_i   (req),
    .last_i  (rr_q),
    .gnt_o   (arb_gnt),
    .idx_o   (arb_idx),
    .valid_o (arb_valid)
  );

  always_comb begin
    for (int i = 0; i < N_CHAR; i++) begin
      rx_arr[i] = req_x[i*COORD_W +: COORD_W];
      ry_arr[i] = req_y[i*COORD_W +: COORD_W];
    end
  end

  assign cand_ok  = (j_q != id_q) && alive_q[j_q];
  assign cand_hit = aabb_overlap(coord_t'(tx_q), coord_t'(ty_q),
                                 coord_t'(px_q[j_q]), coord_t'(py_q[j_q]),
                                 CHAR_W, CHAR_H);

`ifdef COLL_ARENA_BOUNDS_EN
  logic [COORD_W:0] tx_end, ty_end;
  assign tx_end    = {1'b0, tx_q} + (COORD_W+1)'(CHAR_W);
  assign ty_end    = {1'b0, ty_q} + (COORD_W+1)'(CHAR_H);
  assign arena_hit = (int'(tx_end) > ARENA_W) || (int'(ty_end) > ARENA_H);
`else
  // Arena sizes only matter when the bounds check is built in.
  assign arena_hit = (ARENA_W < 0) && (ARENA_H < 0);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      rr_q    <= J_LAST;
      id_q    <= '0;
      j_q     <= '0;
      hit_q   <= 1'b0;
      gnt_q   <= '0;
      tx_q    <= '0;
      ty_q    <= '0;
      alive_q <= '0;
      for (int i = 0; i < N_CHAR; i++) begin
        px_q[i] <= '0;
        py_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      id_q    <= id_d;
      j_q     <= j_d;
      hit_q   <= hit_d;
      gnt_q   <= gnt_d;
      tx_q    <= tx_d;
      ty_q    <= ty_d;
      alive_q <= alive_d;
      for (int i = 0; i < N_CHAR; i++) begin
        px_q[i] <= px_d[i];
        py_q[i] <= py_d[i];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    id_d    = id_q;
    j_d     = j_q;
    hit_d   = hit_q;
    gnt_d   = '0;
    tx_d    = tx_q;
    ty_d    = ty_q;
    alive_d = alive_q;
    for (int i = 0; i < N_CHAR; i++) begin
      px_d[i] = px_q[i];
      py_d[i] = py_q[i];
    end
    unique case (state_q)
      IDLE: begin
        if (arb_valid) begin
          state_d = SCAN;
          rr_d    = arb_idx;
          id_d    = arb_idx;
          j_d     = '0;
          hit_d   = 1'b0;
          gnt_d   = arb_gnt;
          tx_d    = rx_arr[arb_idx];
          ty_d    = ry_arr[arb_idx];
          alive_d = alive;
          for (int i = 0; i < N_CHAR; i++) begin
            px_d[i] = pos_x[i*COORD_W +: COORD_W];
            py_d[i] = pos_y[i*COORD_W +: COORD_W];
          end
        end
      end
      SCAN: begin
        if ((j_q == '0) && arena_hit) hit_d = 1'b1;
        if (cand_ok && cand_hit)      hit_d = 1'b1;
        if (j_q == J_LAST) state_d = RESP;
        else               j_d     = j_q + IDW'(1);
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    gnt          = gnt_q;
    busy         = (state_q != IDLE);
    resp_valid   = (state_q == RESP);
    resp_allowed = (state_q == RESP) && !hit_q;
    resp_id      = id_q;
  end

endmodule

// File: tb/tb_collision_arbiter.sv
// Directed bench for collision_arbiter with a cycle-level behavioural model and literal checks.
// Honours COLL_ARENA_BOUNDS_EN for the arena-edge expectation.
module tb_collision_arbiter;

  localparam int N  = 4;
  localparam int CW = 10;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N-1:0]    req;
  logic [N*CW-1:0] req_x, req_y, pos_x, pos_y;
  logic [N-1:0]    alive;
  logic [N-1:0]    gnt;
  logic            busy, resp_valid, resp_allowed;
  logic [1:0]      resp_id;

  int total = 0;
  int bad   = 0;
  bit done  = 1'b0;

  collision_arbiter dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_x(req_x), .req_y(req_y),
    .pos_x(pos_x), .pos_y(pos_y), .alive(alive), .gnt(gnt), .busy(busy),
    .resp_valid(resp_valid), .resp_allowed(resp_allowed), .resp_id(resp_id)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // m_phase: 0 = idle, k = k-th cycle after a grant (gnt on 1, result on N+1).
  int m_phase = 0;
  int m_last  = N - 1;
  int m_id    = 0;
  bit m_allow = 1'b0;

  function automatic int coord(input logic [N*CW-1:0] v, input int ch);
    return int'(v[ch*CW +: CW]);
  endfunction

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_phase = 0;
      m_last  = N - 1;
      m_id    = 0;
      m_allow = 1'b0;
    end else if (m_phase == 0) begin
      if (|req) begin
        int w, tx, ty;
        bit hit;
        w = -1;
        for (int k = 1; k <= N; k++)
          if (w < 0 && req[(m_last + k) % N]) w = (m_last + k) % N;
        tx  = coord(req_x, w);
        ty  = coord(req_y, w);
        hit = 1'b0;
        for (int j = 0; j < N; j++)
          if (j != w && alive[j] &&
              iabs(tx - coord(pos_x, j)) < 20 && iabs(ty - coord(pos_y, j)) < 20)
            hit = 1'b1;
`ifdef COLL_ARENA_BOUNDS_EN
        if (tx + 20 > 640 || ty + 20 > 480) hit = 1'b1;
`endif
        m_last  = w;
        m_id    = w;
        m_allow = !hit;
        m_phase = 1;
      end
    end else if (m_phase == N + 1) begin
      m_phase = 0;
    end else begin
      m_phase++;
    end
  end

  initial begin
    #2;
    while (!done) begin
      @(negedge clk);
      #1;
      if (done) break;
      chk("gnt",        int'(gnt),        (m_phase == 1) ? (1 << m_id) : 0);
      chk("busy",       int'(busy),       int'(m_phase != 0));
      chk("resp_valid", int'(resp_valid), int'(m_phase == N + 1));
      chk("resp_id",    int'(resp_id),    m_id);
      if (m_phase == N + 1) chk("resp_allowed", int'(resp_allowed), int'(m_allow));
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic set_pos(input int ch, input int x, input int y);
    pos_x[ch*CW +: CW] = CW'(x);
    pos_y[ch*CW +: CW] = CW'(y);
  endtask

  task automatic base_setup();
    set_pos(0, 20, 20);
    set_pos(1, 100, 20);
    set_pos(2, 20, 70);
    set_pos(3, 100, 100);
    alive = '1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    req   = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Waits for any gnt; returns it and the number of cycles waited.
  task automatic wait_gnt(input string name, output logic [N-1:0] g, output int cyc);
    g   = '0;
    cyc = 0;
    while (g == '0 && cyc < 60) begin
      @(negedge clk);
      cyc++;
      g = gnt;
    end
    if (g == '0) chk({name, "_gnt_timeout"}, 0, 1);
  endtask

  task automatic wait_resp(input string name, output int lat);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!resp_valid && lat < 30);
    if (!resp_valid) chk({name, "_resp_timeout"}, 0, 1);
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (busy && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (busy) chk({name, "_idle_timeout"}, 0, 1);
  endtask

  task automatic run_one(input string name, input int ch, input int x, input int y,
                         input int exp_allow, input int exp_wait);
    logic [N-1:0] g;
    int cyc, lat;
    req_x[ch*CW +: CW] = CW'(x);
    req_y[ch*CW +: CW] = CW'(y);
    req[ch] = 1'b1;
    wait_gnt(name, g, cyc);
    req[ch] = 1'b0;
    chk({name, "_gnt"}, int'(g), 1 << ch);
    if (exp_wait > 0) chk({name, "_gnt_wait"}, cyc, exp_wait);
    wait_resp(name, lat);
    chk({name, "_latency"}, lat, N);
    chk({name, "_allowed"}, int'(resp_allowed), exp_allow);
    chk({name, "_id"}, int'(resp_id), ch);
    wait_idle(name);
  endtask

  initial begin
    logic [N-1:0] g;
    int cyc, lat, pulses;
    rst_n = 1'b0;
    req   = '0;
    req_x = '0;
    req_y = '0;
    pos_x = '0;
    pos_y = '0;
    alive = '0;
    base_setup();
    repeat (3) @(negedge clk);
    chk("rst_gnt", int'(gnt), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_valid", int'(resp_valid), 0);
    chk("rst_id", int'(resp_id), 0);
    rst_n = 1'b1;
    @(negedge clk);

    run_one("t1_free", 0, 40, 20, 1, 1);
    run_one("t2_dx19", 1, 39, 20, 0, 0);
    run_one("t2_touch", 1, 40, 20, 1, 0);
    run_one("ty_touch", 0, 20, 50, 1, 0);
    run_one("ty_dy19", 0, 20, 51, 0, 0);

    // snapshot: obstacle moving after the grant must not change the result
    req_x[1*CW +: CW] = CW'(60);
    req_y[1*CW +: CW] = CW'(20);
    req[1] = 1'b1;
    wait_gnt("snap", g, cyc);
    req[1] = 1'b0;
    set_pos(0, 60, 20);
    wait_resp("snap", lat);
    chk("snap_allowed", int'(resp_allowed), 1);
    wait_idle("snap");
    set_pos(0, 20, 20);

    do_reset();
    req = 4'b1111;
    for (int i = 0; i < N; i++) begin
      wait_gnt("t3_rr", g, cyc);
      chk($sformatf("t3_rr_%0d", i), int'(g), 1 << i);
      req = req & ~g;
    end
    wait_idle("t3_rr");
    req = 4'b0101;
    wait_gnt("t3_b0", g, cyc);
    chk("t3_b0", int'(g), 4'b0001);
    req = req & ~g;
    wait_gnt("t3_b2", g, cyc);
    chk("t3_b2", int'(g), 4'b0100);
    req = req & ~g;
    wait_idle("t3_b");

    alive[0] = 1'b0;
    run_one("t4_dead", 1, 30, 25, 1, 0);
    alive[0] = 1'b1;
    run_one("t4_alive", 1, 30, 25, 0, 0);

    // reset mid-scan: pending result must never appear
    req_x[2*CW +: CW] = CW'(200);
    req_y[2*CW +: CW] = CW'(200);
    req[2] = 1'b1;
    wait_gnt("t5", g, cyc);
    req[2] = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("t5_rst_busy", int'(busy), 0);
    chk("t5_rst_gnt", int'(gnt), 0);
    chk("t5_rst_valid", int'(resp_valid), 0);
    chk("t5_rst_id", int'(resp_id), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    pulses = 0;
    repeat (8) begin
      @(negedge clk);
      if (resp_valid) pulses++;
    end
    chk("t5_no_resp", pulses, 0);
    req = 4'b0110;
    wait_gnt("t5_a", g, cyc);
    chk("t5_first", int'(g), 4'b0010);
    req = req & ~g;
    wait_gnt("t5_b", g, cyc);
    chk("t5_second", int'(g), 4'b0100);
    req = req & ~g;
    wait_idle("t5");

`ifdef COLL_ARENA_BOUNDS_EN
    run_one("t6_arena", 3, 625, 100, 0, 0);
`else
    run_one("t6_arena", 3, 625, 100, 1, 0);
`endif

    repeat (2) @(negedge clk);
    done = 1'b1;
    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
